// File: rtl/digital_tube_driver_pkg.sv
// Shared definitions for the digital-tube display path.
// Contents: register address map, blank/off output constants, and the
// segment bit order {dp,g,f,e,d,c,b,a}, where a is bit 0 and dp is bit 7.
// All segment and enable levels are active-low.
package digital_tube_driver_pkg;

    localparam logic [1:0] TUBE_ADDR_LO    = 2'd0;  // digits 3..0, one hex nibble each
    localparam logic [1:0] TUBE_ADDR_HI    = 2'd1;  // digits 7..4
    localparam logic [1:0] TUBE_ADDR_BLANK = 2'd2;  // 1 = digit off
    localparam logic [1:0] TUBE_ADDR_DP    = 2'd3;  // 1 = decimal point lit

    localparam logic [7:0] BLANK_SHAPE = 8'hFF;     // all segments dark
    localparam logic [7:0] ALL_OFF     = 8'hFF;     // no digit enabled

    localparam int SEG_WIDTH = 7;                   // a..g
    localparam int SEG_DP    = 7;                   // dp sits above g

    // Build the full pin pattern from the a..g code and the dp request.
    function automatic logic [7:0] tube_shape(input logic dp_lit,
                                              input logic [SEG_WIDTH-1:0] seg);
        logic [7:0] shape;
        shape                  = {1'b1, seg};
        shape[SEG_DP]          = ~dp_lit;
        return shape;
    endfunction

endpackage

// File: rtl/digital_tube_driver_hex_to_segment.sv
// hex_to_segment: combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  active-low segments, bit 0 = a ... bit 6 = g
module hex_to_segment
    import digital_tube_driver_pkg::*;
(
    input  logic [3:0]           nibble,
    output logic [SEG_WIDTH-1:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/digital_tube_driver.sv
// digital_tube_driver: CPU-writable 8-digit multiplexed seven-segment driver.
// Ports:
//   iCpuClock         in  1   clock for all state
//   iCpuReset         in  1   asynchronous reset, active-low
//   iDoTubeWrite      in  1   register write strobe
//   iTubeAddress      in  2   register select (lo word, hi word, blank, dp)
//   iTubeDataToWrite  in  16  write data; masks use [7:0]
//   oTubesNotEnable   out 8   digit enables, active-low, at most one low
//   oTubeShape        out 8   {dp,g,f,e,d,c,b,a}, active-low
module digital_tube_driver
    import digital_tube_driver_pkg::*;
#(
    parameter int SCAN_DIV = 20000,
    parameter int DIGITS   = 8
) (
    input  logic        iCpuClock,
    input  logic        iCpuReset,
    input  logic        iDoTubeWrite,
    input  logic [1:0]  iTubeAddress,
    input  logic [15:0] iTubeDataToWrite,
    output logic [7:0]  oTubesNotEnable,
    output logic [7:0]  oTubeShape
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [15:0]          lo_word;
    logic [15:0]          hi_word;
    logic [7:0]           blank_mask;
    logic [7:0]           dp_mask;
    logic [CNT_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]     digit_idx;
    logic                 first_cycle;

    logic                 wrap;
    logic [15:0]          cur_word;
    logic [3:0]           cur_nibble;
    logic [SEG_WIDTH-1:0] cur_seg;

    assign wrap     = (scan_cnt == CNT_LAST);
    assign cur_word = digit_idx[2] ? hi_word : lo_word;

    always_comb begin
        cur_nibble = cur_word[3:0];
        case (digit_idx[1:0])
            2'd0: cur_nibble = cur_word[3:0];
            2'd1: cur_nibble = cur_word[7:4];
            2'd2: cur_nibble = cur_word[11:8];
            2'd3: cur_nibble = cur_word[15:12];
            default: cur_nibble = cur_word[3:0];
        endcase
    end

    hex_to_segment u_hex_to_segment (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Display outputs are computed from the pre-edge index and registers, so a
    // write landing on the same edge only becomes visible one cycle later.
    always_ff @(posedge iCpuClock or negedge iCpuReset) begin
        if (!iCpuReset) begin
            lo_word         <= '0;
            hi_word         <= '0;
            blank_mask      <= 8'hFF;
            dp_mask         <= '0;
            scan_cnt        <= '0;
            digit_idx       <= '0;
            first_cycle     <= 1'b1;
            oTubesNotEnable <= ALL_OFF;
            oTubeShape      <= BLANK_SHAPE;
        end else begin
            if (iDoTubeWrite) begin
                case (iTubeAddress)
                    TUBE_ADDR_LO:    lo_word    <= iTubeDataToWrite;
                    TUBE_ADDR_HI:    hi_word    <= iTubeDataToWrite;
                    TUBE_ADDR_BLANK: blank_mask <= iTubeDataToWrite[7:0];
                    TUBE_ADDR_DP:    dp_mask    <= iTubeDataToWrite[7:0];
                    default: ;
                endcase
            end

            first_cycle <= 1'b0;
            if (wrap) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + IDX_W'(1);
            end else begin
                scan_cnt  <= scan_cnt + CNT_W'(1);
            end

            // One dark cycle at each digit change keeps the old pattern from
            // bleeding onto the next digit while the drivers switch.
            if (wrap || first_cycle || blank_mask[digit_idx]) begin
                oTubesNotEnable <= ALL_OFF;
                oTubeShape      <= BLANK_SHAPE;
            end else begin
                oTubesNotEnable <= ~(8'h01 << digit_idx);
                oTubeShape      <= tube_shape(dp_mask[digit_idx], cur_seg);
            end
        end
    end

endmodule

// File: tb/tb_digital_tube_driver.sv
module tb_digital_tube_driver;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] data = 16'h0000;
    logic [7:0]  tube_en;
    logic [7:0]  tube_shape;

    always #5 clk = ~clk;

    digital_tube_driver #(.SCAN_DIV(SCAN_DIV), .DIGITS(8)) dut (
        .iCpuClock        (clk),
        .iCpuReset        (rst_n),
        .iDoTubeWrite     (wr),
        .iTubeAddress     (addr),
        .iTubeDataToWrite (data),
        .oTubesNotEnable  (tube_en),
        .oTubeShape       (tube_shape)
    );

    typedef struct {
        logic [7:0] en;
        logic [7:0] shape;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Hand-computed enables and shapes for nibbles 0..7 at each digit.
    logic [7:0] en_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] shp_a   [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] shp_b   [8] = '{8'h80, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every edge, check the one-low invariant and pop one expectation.
    always @(posedge clk) begin
        #1;
        n_cmp++;
        if ($countones(~tube_en) > 1) begin
            n_bad++;
            $display("FAIL one_hot_low: got %h, required at most one 0 bit (t=%0t)", tube_en, $time);
        end
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, " en"}, tube_en, mon_e.en);
            check({mon_e.name, " shape"}, tube_shape, mon_e.shape);
        end
    end

    task automatic tick(input bit chk, input logic [7:0] e_en, input logic [7:0] e_sh,
                        input string name);
        exp_t e;
        if (chk) begin
            e.en = e_en;
            e.shape = e_sh;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wr_tick(input logic [1:0] a, input logic [15:0] d,
                           input logic [7:0] e_en, input logic [7:0] e_sh, input string name);
        wr = 1'b1;
        addr = a;
        data = d;
        tick(1'b1, e_en, e_sh, name);
        wr = 1'b0;
    endtask

    task automatic expect_digit(input logic [7:0] e_en, input logic [7:0] e_sh, input string name);
        repeat (3) tick(1'b1, e_en, e_sh, name);
        tick(1'b1, 8'hFF, 8'hFF, {name, " gap"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: outputs dark.
        #12;
        check("reset en", tube_en, 8'hFF);
        check("reset shape", tube_shape, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: everything blanked.
        repeat (64) tick(1'b1, 8'hFF, 8'hFF, "idle");

        // Load 3210/7654, unblank; index is at 1 after the wrap.
        wr_tick(TUBE_ADDR(0), 16'h3210, 8'hFF, 8'hFF, "wr lo");
        wr_tick(TUBE_ADDR(1), 16'h7654, 8'hFF, 8'hFF, "wr hi");
        wr_tick(TUBE_ADDR(2), 16'h0000, 8'hFF, 8'hFF, "wr blank");
        tick(1'b1, 8'hFF, 8'hFF, "wrap0");
        for (int k = 1; k <= 8; k++) expect_digit(en_tab[k % 8], shp_a[k % 8], "frame");

        // FEDC with dp on digit0 and digits 4..7 blanked.
        wr_tick(TUBE_ADDR(0), 16'hFEDC, 8'hFD, 8'hF9, "p3 wr lo");
        wr_tick(TUBE_ADDR(3), 16'h0001, 8'hFD, 8'hA1, "p3 wr dp");
        wr_tick(TUBE_ADDR(2), 16'h00F0, 8'hFD, 8'hA1, "p3 wr blank");
        tick(1'b1, 8'hFF, 8'hFF, "p3 wrap");
        expect_digit(8'hFB, 8'h86, "p3 d2");
        expect_digit(8'hF7, 8'h8E, "p3 d3");
        repeat (16) tick(1'b1, 8'hFF, 8'hFF, "p3 blanked");
        expect_digit(8'hFE, 8'h46, "p3 d0 dp");
        expect_digit(8'hFD, 8'hA1, "p3 d1");

        // Restore plain digits, then write on the wrap edge into digit 0.
        wr_tick(TUBE_ADDR(3), 16'h0000, 8'hFB, 8'h86, "p4 wr dp");
        wr_tick(TUBE_ADDR(0), 16'h3210, 8'hFB, 8'h86, "p4 wr lo");
        wr_tick(TUBE_ADDR(2), 16'h0000, 8'hFB, 8'hA4, "p4 wr blank");
        tick(1'b1, 8'hFF, 8'hFF, "p4 wrap");
        for (int k = 3; k <= 6; k++) expect_digit(en_tab[k], shp_a[k], "p4 run");
        repeat (3) tick(1'b1, 8'h7F, 8'hF8, "p4 d7");
        wr_tick(TUBE_ADDR(0), 16'h3218, 8'hFF, 8'hFF, "wr on wrap");
        addr = 2'd0;
        data = 16'hFFFF;
        expect_digit(8'hFE, 8'h80, "new nibble");
        addr = 2'd2;
        expect_digit(8'hFD, 8'hF9, "no strobe");
        addr = 2'd0;
        data = 16'h0000;

        // Three frames, wrapping through digit 7 to digit 0.
        for (int f = 0; f < 3; f++)
            for (int j = 0; j < 8; j++)
                expect_digit(en_tab[(2 + j) % 8], shp_b[(2 + j) % 8], "frames");

        // Mid-digit asynchronous reset.
        tick(1'b1, 8'hFB, 8'hA4, "pre rst");
        tick(1'b1, 8'hFB, 8'hA4, "pre rst");
        #2;
        check("before rst en", tube_en, 8'hFB);
        rst_n = 1'b0;
        #1;
        check("async rst en", tube_en, 8'hFF);
        check("async rst shape", tube_shape, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_tick(TUBE_ADDR(2), 16'h0000, 8'hFF, 8'hFF, "first after rst");
        tick(1'b1, 8'hFE, 8'hC0, "restart d0");
        tick(1'b1, 8'hFE, 8'hC0, "restart d0");
        tick(1'b1, 8'hFF, 8'hFF, "restart wrap");
        for (int k = 1; k < 8; k++) expect_digit(en_tab[k], 8'hC0, "restart run");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb drain: got %0d pending, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic [1:0] TUBE_ADDR(input int a);
        return 2'(a);
    endfunction

endmodule
